// File: rtl/serial2pall.sv
// Serial-to-parallel word assembler: LSB-first bits qualified by iStart, 1-cycle latency to oData/oValid.
// No stall: iAck only clears oValid; an unacknowledged word is overwritten and flagged by sticky oOverrun.
module serial2pall #(
  parameter int WIDTH = 32
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iData,
  input  logic                     iStart,
  input  logic                     iAck,
  output logic [WIDTH-1:0]         oData,
  output logic                     oValid,
  output logic [$clog2(WIDTH)-1:0] oBitCnt,
  output logic                     oOverrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] shifted;

  // New bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
  assign shifted = {iData, shr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shr_d   = shr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (iAck) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          shr_d   = shifted;
          cnt_d   = CNT_W'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (iStart) begin
          shr_d = shifted;
          if (cnt_q == LAST_BIT) begin
            // Completion wins over a same-cycle ack; ack only prevents the overrun.
            cnt_d   = '0;
            data_d  = shifted;
            valid_d = 1'b1;
            if (valid_q && !iAck) begin
              ovr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= S_IDLE;
      shr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign oData    = data_q;
  assign oValid   = valid_q;
  assign oBitCnt  = cnt_q;
  assign oOverrun = ovr_q;

endmodule

// File: doc/serial2pall.md
SERIAL2PALL -- requirements
Module: serial2pall

Interface
REQ-001 Parameter: WIDTH, 32, word width in bits; all widths and counts below are stated for WIDTH=32.
REQ-002 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-003 iReset  input  1  reset, synchronous and active-high; sampled on the iClk rising edge.
REQ-004 iData  input  1  serial data bit, LSB of each word first.
REQ-005 iStart  input  1  serial-valid qualifier; iData is sampled on every cycle where iStart=1.
REQ-006 iAck  input  1  consumer accepts the word currently on oData.
REQ-007 oData  output  32  last completed parallel word.
REQ-008 oValid  output  1  oData holds a word not yet acknowledged.
REQ-009 oBitCnt  output  5  bits received so far in the current word (0..31).
REQ-010 oOverrun  output  1  sticky; a word completed while the previous one was unacknowledged.

Function
REQ-011 The state machine SHALL have two states: IDLE (no word in progress) and SHIFT (word in progress).
REQ-012 IDLE, iStart=1: sample iData into the shift register, set oBitCnt=1, enter SHIFT.
REQ-013 IDLE, iStart=0: hold shift register; oBitCnt stays 0.
REQ-014 SHIFT, iStart=1: shift register <= {iData, shr[31:1]}; oBitCnt increments by 1.
REQ-015 SHIFT, iStart=1, oBitCnt=31 (32nd bit): oData <= {iData, shr[31:1]}; oValid <= 1; oBitCnt <= 0; remain in SHIFT so back-to-back words need no idle gap.
REQ-016 Word mapping: the first bit sampled SHALL appear at oData[0]; the 32nd bit at oData[31].
REQ-017 Latency: oData/oValid update on the edge that samples the 32nd bit, visible in the following cycle.
REQ-018 SHIFT, iStart=0 with oBitCnt≠0: discard the partial word, oBitCnt <= 0, enter IDLE; oData, oValid and oOverrun unchanged.
REQ-019 SHIFT, iStart=0 with oBitCnt=0 (word boundary): enter IDLE with no other effect.
REQ-020 iAck=1 while oValid=1 clears oValid on the next edge; iAck while oValid=0 has no effect.
REQ-021 Simultaneous iAck=1 and word completion: the new word loads, oValid stays 1, oOverrun not set.
REQ-022 Word completion with oValid=1 and iAck=0: oData is overwritten with the new word, oValid stays 1, oOverrun set to 1.
REQ-023 oOverrun SHALL clear only on reset.
REQ-024 oBitCnt SHALL never exceed 31; the counter wraps 31 -> 0 only on word completion.

Reset
REQ-025 iReset=1 at an edge: state=IDLE, shift register=0, oData=32'd0, oValid=0, oBitCnt=0, oOverrun=0.
REQ-026 Reset SHALL take priority over iStart and iAck in the same cycle.
REQ-027 Reset mid-word SHALL discard the partial word; the first iStart=1 after reset is bit 0 of a new word.

Verification
REQ-028 Reset, then 32 cycles iStart=1 carrying 32'hA5C3_0F81 LSB first -> one cycle later oData=32'hA5C3_0F81, oValid=1, oBitCnt=0, oOverrun=0.
REQ-029 Two words 32'h0000_0001 and 32'h8000_0000 back-to-back, iAck pulsed on the cycle after the first word is valid -> second word on oData, oValid=1, oOverrun=0.
REQ-030 Two words back-to-back with iAck held 0 -> oData = second word, oValid=1, oOverrun=1; oOverrun remains 1 through later acknowledged words until iReset.
REQ-031 iStart=1 for 10 bits, then 0 for 1 cycle, then 32 bits of 32'hFFFF_0000 -> oBitCnt reaches 10, returns to 0; final oData=32'hFFFF_0000 with no residue from the partial.
REQ-032 iAck asserted on the exact completion cycle of the second word while the first is still valid -> oValid stays 1, oData = second word, oOverrun=0.
REQ-033 iReset asserted at oBitCnt=20 -> next cycle all outputs zero, then a full 32-bit word of 32'h1234_5678 -> oData=32'h1234_5678.
